// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter/sequencer sharing one SPI master (newd/din/dout/done) among N_REQ clients.
// Optional WAIT-state abort timer is enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_req_arbiter #(
   parameter int N_REQ       = 4,
   parameter int DW          = 12,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req,
   input  logic [N_REQ*DW-1:0] req_data,
   output logic [N_REQ-1:0]   gnt,
   output logic [N_REQ-1:0]   ack,
   output logic [DW-1:0]      rsp_data,
   output logic               err,
   output logic               busy,
   output logic               spi_newd,
   output logic [DW-1:0]      spi_din,
   input  logic [DW-1:0]      spi_dout,
   input  logic               spi_done
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_param
      $error("spi_req_arbiter: parameter out of range");
   end

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

   state_t            state, state_n;
   logic [IW-1:0]     last, last_n;
   logic [IW-1:0]     win, win_n;
   logic [IW-1:0]     pick;
   logic              found;
   logic [N_REQ-1:0]  gnt_n, ack_n;
   logic              busy_n, newd_n, err_n;
   logic [DW-1:0]     din_n, rsp_n;

`ifdef SPI_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   logic [CW-1:0] cnt, cnt_n;
   logic          err_q;
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   // Rotating search starting just after the last served requester.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         if (!found && req[(int'(last) + k) % N_REQ]) begin
            found = 1'b1;
            pick  = IW'((int'(last) + k) % N_REQ);
         end
      end
   end

   always_comb begin
      state_n = state;
      last_n  = last;
      win_n   = win;
      gnt_n   = gnt;
      ack_n   = '0;
      err_n   = 1'b0;
      newd_n  = 1'b0;
      din_n   = spi_din;
      rsp_n   = rsp_data;
`ifdef SPI_ARB_TIMEOUT_EN
      cnt_n   = cnt;
`endif
      case (state)
         IDLE: begin
            if (found) begin
               win_n       = pick;
               gnt_n       = '0;
               gnt_n[pick] = 1'b1;
               din_n       = req_data[int'(pick)*DW +: DW];
               state_n     = LAUNCH;
            end
         end
         LAUNCH: begin
            newd_n  = 1'b1;
            state_n = WAIT;
`ifdef SPI_ARB_TIMEOUT_EN
            cnt_n   = '0;
`endif
         end
         WAIT: begin
            if (spi_done) begin
               rsp_n      = spi_dout;
               ack_n[win] = 1'b1;
               state_n    = RESP;
            end
`ifdef SPI_ARB_TIMEOUT_EN
            // A late done in the limit cycle still counts as a normal completion.
            else if (cnt == CW'(TIMEOUT_CYC)) begin
               rsp_n      = '0;
               ack_n[win] = 1'b1;
               err_n      = 1'b1;
               state_n    = RESP;
            end else begin
               cnt_n = cnt + 1'b1;
            end
`endif
         end
         RESP: begin
            last_n  = win;
            gnt_n   = '0;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
      busy_n = (state_n != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         last     <= IW'(N_REQ - 1);
         win      <= '0;
         gnt      <= '0;
         ack      <= '0;
         busy     <= 1'b0;
         spi_newd <= 1'b0;
         spi_din  <= '0;
         rsp_data <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
         cnt      <= '0;
         err_q    <= 1'b0;
`endif
      end else begin
         state    <= state_n;
         last     <= last_n;
         win      <= win_n;
         gnt      <= gnt_n;
         ack      <= ack_n;
         busy     <= busy_n;
         spi_newd <= newd_n;
         spi_din  <= din_n;
         rsp_data <= rsp_n;
`ifdef SPI_ARB_TIMEOUT_EN
         cnt      <= cnt_n;
         err_q    <= err_n;
`endif
      end
   end

`ifndef SPI_ARB_TIMEOUT_EN
   logic unused_err;
   assign unused_err = err_n;
`endif

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Self-checking bench for spi_req_arbiter: bench-driven SPI responder with a response scoreboard.
module tb_spi_req_arbiter;

   localparam int N  = 4;
   localparam int DW = 12;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    gnt, ack;
   logic [DW-1:0]   rsp_data;
   logic            err, busy, spi_newd;
   logic [DW-1:0]   spi_din, spi_dout;
   logic            spi_done;

   typedef struct {
      int            idx;
      logic [DW-1:0] data;
      logic          e;
   } exp_t;
   exp_t exp_q[$];

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   spi_req_arbiter #(.N_REQ(N), .DW(DW), .TIMEOUT_CYC(16)) dut (
      .clk(clk), .rst(rst), .req(req), .req_data(req_data),
      .gnt(gnt), .ack(ack), .rsp_data(rsp_data), .err(err), .busy(busy),
      .spi_newd(spi_newd), .spi_din(spi_din), .spi_dout(spi_dout), .spi_done(spi_done)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = '0;
      spi_done = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // One complete transaction for the expected winner; optional spurious done in LAUNCH.
   task automatic run_transfer(input int exp_idx, input logic [DW-1:0] resp,
                               input int delay, input bit drop, input bit spurious);
      int n;
      logic [DW-1:0] exp_din;
      exp_t e;
      n = 0;
      while (gnt == '0 && n < 20) begin
         tick();
         n++;
      end
      checks++; if (gnt !== 4'(1 << exp_idx)) $display("[TB] FAIL grant: got %b want %b", gnt, 4'(1 << exp_idx)); else passed++;
      checks++; if (busy !== 1'b1) $display("[TB] FAIL busy_launch: got %b want 1", busy); else passed++;
      exp_din = req_data[exp_idx*DW +: DW];
      if (spurious) spi_done = 1'b1;
      tick();
      spi_done = 1'b0;
      checks++; if (spi_newd !== 1'b1) $display("[TB] FAIL newd_pulse: got %b want 1", spi_newd); else passed++;
      checks++; if (spi_din !== exp_din) $display("[TB] FAIL spi_din: got %h want %h", spi_din, exp_din); else passed++;
      tick();
      checks++; if (spi_newd !== 1'b0 || ack !== '0) $display("[TB] FAIL newd_drop: got newd=%b ack=%b want 0/0", spi_newd, ack); else passed++;
      repeat (delay) tick();
      spi_dout = resp;
      spi_done = 1'b1;
      exp_q.push_back('{exp_idx, resp, 1'b0});
      tick();
      spi_done = 1'b0;
      spi_dout = DW'($urandom);
      e = exp_q.pop_front();
      checks++; if (ack !== 4'(1 << e.idx)) $display("[TB] FAIL ack: got %b want %b", ack, 4'(1 << e.idx)); else passed++;
      checks++; if (rsp_data !== e.data) $display("[TB] FAIL rsp_data: got %h want %h", rsp_data, e.data); else passed++;
      checks++; if (err !== e.e) $display("[TB] FAIL err: got %b want %b", err, e.e); else passed++;
      checks++; if (gnt !== 4'(1 << e.idx)) $display("[TB] FAIL gnt_held: got %b want %b", gnt, 4'(1 << e.idx)); else passed++;
      if (drop) req[exp_idx] = 1'b0;
      tick();
      checks++; if (ack !== '0 || gnt !== '0) $display("[TB] FAIL resp_exit: got ack=%b gnt=%b want 0/0", ack, gnt); else passed++;
      checks++; if (rsp_data !== e.data) $display("[TB] FAIL rsp_hold: got %h want %h", rsp_data, e.data); else passed++;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if ({gnt, ack, err, busy, spi_newd} !== '0) $display("[TB] FAIL reset_ctrl: got %b want 0", {gnt, ack, err, busy, spi_newd}); else passed++;
      checks++; if ({spi_din, rsp_data} !== '0) $display("[TB] FAIL reset_data: got %h want 0", {spi_din, rsp_data}); else passed++;
   endtask

   task automatic test_single();
      req_data[0 +: DW] = 12'hA5C;
      req = 4'b0001;
      tick();
      checks++; if (gnt !== 4'b0001) $display("[TB] FAIL single_latency: got %b want 0001", gnt); else passed++;
      run_transfer(0, 12'h3C1, 2, 1'b1, 1'b0);
   endtask

   task automatic test_round_robin();
      do_reset();
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'($urandom);
         req = 4'b1111;
         for (int i = 0; i < N; i++) run_transfer(i, DW'(12'h3C1 ^ (i * 12'h111)), i, 1'b1, 1'b0);
      end
   endtask

   task automatic test_fairness();
      req = 4'b0100;
      run_transfer(2, 12'h222, 1, 1'b1, 1'b0);
      req = 4'b0101;
      run_transfer(0, 12'h000, 0, 1'b1, 1'b0);
      run_transfer(2, 12'hFFF, 3, 1'b1, 1'b0);
   endtask

   task automatic test_spurious_done();
      tick();
      spi_done = 1'b1;
      tick();
      spi_done = 1'b0;
      checks++; if (ack !== '0 || busy !== 1'b0 || gnt !== '0) $display("[TB] FAIL idle_done: got ack=%b busy=%b gnt=%b want idle", ack, busy, gnt); else passed++;
      req = 4'b0001;
      run_transfer(0, 12'h5A5, 4, 1'b1, 1'b1);
   endtask

   task automatic test_reset_mid_wait();
      int n;
      req = 4'b0001;
      run_transfer(0, 12'h123, 0, 1'b1, 1'b0);
      req = 4'b0100;
      n = 0;
      while (gnt == '0 && n < 20) begin
         tick();
         n++;
      end
      tick();
      tick();
      rst = 1'b1;
      req = '0;
      tick();
      rst = 1'b0;
      checks++; if ({gnt, ack, err, busy, spi_newd} !== '0) $display("[TB] FAIL midreset_ctrl: got %b want 0", {gnt, ack, err, busy, spi_newd}); else passed++;
      checks++; if ({spi_din, rsp_data} !== '0) $display("[TB] FAIL midreset_data: got %h want 0", {spi_din, rsp_data}); else passed++;
      spi_done = 1'b1;
      tick();
      spi_done = 1'b0;
      tick();
      checks++; if (ack !== '0 || busy !== 1'b0) $display("[TB] FAIL midreset_noack: got ack=%b busy=%b want 0/0", ack, busy); else passed++;
      req = 4'b0011;
      run_transfer(0, 12'h0F0, 1, 1'b1, 1'b0);
      run_transfer(1, 12'hF0F, 2, 1'b1, 1'b0);
   endtask

   task automatic test_continuous();
      req = 4'b0010;
      run_transfer(1, 12'h001, 0, 1'b0, 1'b0);
      run_transfer(1, 12'h002, 1, 1'b0, 1'b0);
      run_transfer(1, 12'h003, 2, 1'b1, 1'b0);
   endtask

`ifdef SPI_ARB_TIMEOUT_EN
   task automatic test_timeout();
      int n;
      exp_t e;
      req = 4'b1000;
      n = 0;
      while (gnt == '0 && n < 20) begin
         tick();
         n++;
      end
      exp_q.push_back('{3, 12'h000, 1'b1});
      tick();
      repeat (16) tick();
      checks++; if (ack !== '0) $display("[TB] FAIL timeout_early: got %b want 0", ack); else passed++;
      tick();
      e = exp_q.pop_front();
      checks++; if (ack !== 4'(1 << e.idx) || err !== e.e) $display("[TB] FAIL timeout_ack: got ack=%b err=%b want %b/1", ack, err, 4'(1 << e.idx)); else passed++;
      checks++; if (rsp_data !== e.data) $display("[TB] FAIL timeout_rsp: got %h want %h", rsp_data, e.data); else passed++;
      req = '0;
      tick();
      req = 4'b0001;
      run_transfer(0, 12'hABC, 1, 1'b1, 1'b0);
   endtask
`endif

   initial begin
      rst = 1'b1;
      req = '0;
      req_data = '0;
      spi_dout = '0;
      spi_done = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_fairness();
      test_spurious_done();
      test_reset_mid_wait();
      test_continuous();
`ifdef SPI_ARB_TIMEOUT_EN
      test_timeout();
`endif
      checks++; if (exp_q.size() != 0) $display("[TB] FAIL scoreboard_drain: got %0d want 0", exp_q.size()); else passed++;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout want completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/spi_req_arbiter.md
Name: spi_req_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one SPI master datapath (newd/din/dout/done handshake) among N_REQ requesters.
- Grants one requester, launches a single transfer with a one-cycle spi_newd pulse, waits for spi_done, and returns the received word with a one-cycle ack.
- Sits between client logic and the SPI top; both are on the same clk/rst.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DW, 12, SPI data word width; matches the SPI top din/dout width.
- TIMEOUT_CYC, 1024, maximum WAIT cycles before abort; used only when SPI_ARB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req  in  N_REQ  per-requester request level.
- req_data  in  N_REQ*DW  packed TX words; requester i at [i*DW +: DW].
- gnt  out  N_REQ  one-hot grant, held for the whole transaction.
- ack  out  N_REQ  one-cycle completion pulse to the granted requester.
- rsp_data  out  DW  received word; valid in the ack cycle and held until the next capture.
- err  out  1  abort flag, qualifies ack.
- busy  out  1  high in any state other than IDLE.
- spi_newd  out  1  start pulse to SPI top.
- spi_din  out  DW  TX word to SPI top.
- spi_dout  in  DW  RX word from SPI top.
- spi_done  in  1  SPI transfer-complete pulse.

Behaviour:
- Reset (synchronous, rst=1 at the edge):
  - FSM goes to IDLE.
  - gnt, ack, err, busy, spi_newd, spi_din and rsp_data all clear to 0.
  - Round-robin pointer last is set to N_REQ-1, so requester 0 has first priority.
  - Reset mid-transaction aborts with no ack; spi_newd is guaranteed low on the following cycle.
- FSM states and transitions; all outputs are registered:
  - IDLE:
    - If req is non-zero, pick the first set bit searching last+1, last+2, ... mod N_REQ.
    - Register gnt for the winner and latch spi_din from its req_data slice. Go to LAUNCH.
    - Otherwise stay in IDLE.
  - LAUNCH: spi_newd=1 for exactly this one cycle. Go to WAIT.
  - WAIT:
    - spi_newd=0.
    - On spi_done=1: capture spi_dout into rsp_data, set ack[winner]=1, go to RESP.
  - RESP:
    - ack high for this one cycle; gnt is still held.
    - last is updated to the winner index.
    - Next cycle: gnt=0, ack=0, go to IDLE.
- Latency:
  - req rising in IDLE → gnt next cycle → spi_newd the cycle after.
  - spi_done → ack the next cycle.
  - Back-to-back transactions are separated by at least one IDLE cycle.
- Handshake rules:
  - A requester holds req and req_data stable until it samples ack=1.
  - It then deasserts req from the following cycle; req still high in IDLE is treated as a new request.
  - req_data is sampled only in IDLE at grant; later changes are ignored.
  - A requester dropping req after grant does not cancel the transfer; the transfer completes and ack still pulses.
- Boundary conditions:
  - spi_done seen in IDLE, LAUNCH or RESP is ignored.
  - Requests arriving in LAUNCH, WAIT or RESP wait for the next IDLE.
  - All N_REQ requesting: served in strict rotation, each exactly once per N_REQ transactions.
  - The pointer wraps N_REQ-1 → 0.
  - A single requester requesting continuously is granted every transaction.
- Width rule: rsp_data and spi_din are exactly DW bits; there is no sign or zero extension.

Optional Feature:
- Macro: SPI_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on WAIT entry and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYC with no spi_done, go to RESP with ack[winner]=1, err=1 and rsp_data=0.
  - The pointer is still advanced.
  - spi_done arriving in the same cycle as the limit wins: normal completion, err=0.
- Not defined:
  - WAIT lasts until spi_done, with no limit.
  - err is tied 0 and no counter logic exists.

Test Plan:
- Single request: rst then req=4'b0001, req_data[11:0]=12'hA5C, SPI returns 12'h3C1 → gnt=0001 one cycle after req, one spi_newd pulse with spi_din=A5C, ack[0] one cycle after done, rsp_data=3C1, err=0.
- Round-robin: req=4'b1111 held, each requester drops req after its ack, 4 transfers → grant order 0,1,2,3. Then req=1111 again → order 0,1,2,3 (wrap).
- Fairness after service: serve requester 2, then req=4'b0101 → requester 0 granted next (search starts at 3).
- Spurious done: spi_done pulsed in IDLE and LAUNCH → no ack, FSM unaffected, the transfer still waits for a later done.
- Reset mid-WAIT: rst during WAIT → next cycle all outputs 0, FSM in IDLE, no ack. Then req=0010 → requester 1 granted (last=N_REQ-1 after reset; first set bit from 0).
- Timeout (SPI_ARB_TIMEOUT_EN, TIMEOUT_CYC=16): never assert spi_done → ack and err high 17 cycles after WAIT entry, rsp_data=0, next request served normally.
